// File: rtl/pipe_pkg.sv
// Shared encodings for the execute stage: ALU opcodes, forwarding selects and
// the sequential-multiplier state encoding.
package pipe_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_NOR = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;
  localparam logic [3:0] ALU_MUL = 4'b1100;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/ex_stage_if.sv
// Execute-stage bus: E-side control/data from ID/EX, forwarding inputs,
// and the M-side outputs of the EX/MEM register plus hazard signals.
interface ex_stage_if #(
  parameter int DATA_W = 32
);
  logic              RegWriteE;
  logic              MemtoRegE;
  logic              MemWriteE;
  logic              ALUSrcE;
  logic              RegDstE;
  logic [3:0]        ALUControlE;
  logic [DATA_W-1:0] RegOut1E;
  logic [DATA_W-1:0] RegOut2E;
  logic [4:0]        RtE;
  logic [4:0]        RdE;
  logic [DATA_W-1:0] ExtendImmE;
  logic [1:0]        ForwardAE;
  logic [1:0]        ForwardBE;
  logic [DATA_W-1:0] ResultW;

  logic              StallE;
  logic              RegWriteM;
  logic              MemtoRegM;
  logic              MemWriteM;
  logic [DATA_W-1:0] ALUOutM;
  logic [DATA_W-1:0] WriteDataM;
  logic [4:0]        WriteRegM;
  logic [4:0]        WriteRegE;

  modport master (
    output RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ALUControlE,
           RegOut1E, RegOut2E, RtE, RdE, ExtendImmE, ForwardAE, ForwardBE, ResultW,
    input  StallE, RegWriteM, MemtoRegM, MemWriteM, ALUOutM, WriteDataM,
           WriteRegM, WriteRegE
  );

  modport slave (
    input  RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ALUControlE,
           RegOut1E, RegOut2E, RtE, RdE, ExtendImmE, ForwardAE, ForwardBE, ResultW,
    output StallE, RegWriteM, MemtoRegM, MemWriteM, ALUOutM, WriteDataM,
           WriteRegM, WriteRegE
  );
endinterface

// File: rtl/ex_stage_seq_multiplier.sv
// Iterative shift-add multiplier (IDLE/BUSY/DONE), retiring MUL_BITS
// multiplier bits per BUSY cycle. Only built when EX_MUL_EN is defined.
`ifdef EX_MUL_EN
module seq_multiplier
  import pipe_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int MUL_BITS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [4:0]        tag_i,
  output logic              stall_o,
  output logic              done_o,
  output logic [DATA_W-1:0] product_o,
  output logic [4:0]        tag_o
);
  localparam int STEPS = DATA_W / MUL_BITS;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  mul_state_e        state_q;
  logic [CNT_W-1:0]  count_q;
  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] mcand_q;
  logic [DATA_W-1:0] mplier_q;
  logic [4:0]        tag_q;
  logic [DATA_W-1:0] partial;

  always_comb begin
    partial = '0;
    for (int j = 0; j < MUL_BITS; j++) begin
      if (mplier_q[j]) partial = partial + (mcand_q << j);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      tag_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            mcand_q  <= a_i;
            mplier_q <= b_i;
            tag_q    <= tag_i;
            acc_q    <= '0;
            count_q  <= '0;
            state_q  <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          acc_q    <= acc_q + partial;
          mcand_q  <= mcand_q << MUL_BITS;
          mplier_q <= mplier_q >> MUL_BITS;
          if (count_q == CNT_W'(STEPS - 1)) state_q <= ST_DONE;
          else                              count_q <= count_q + CNT_W'(1);
        end
        // The MUL still held upstream is consumed here and does not restart.
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Stall drops the moment reset asserts, even if a MUL code is still presented.
  assign stall_o   = rst_n & (((state_q == ST_IDLE) & start_i) | (state_q == ST_BUSY));
  assign done_o    = (state_q == ST_DONE);
  assign product_o = acc_q;
  assign tag_o     = tag_q;

endmodule
`endif

// File: rtl/ex_stage.sv
// Execute stage: forwarding muxes, ALU and the EX/MEM pipeline register.
// Define EX_MUL_EN to build the multi-cycle multiplier and StallE logic.
module ex_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int MUL_BITS = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  ex_stage_if.slave bus
);
  logic [DATA_W-1:0] src_a, fwd_b, src_b, alu_y;
  logic [4:0]        shamt;

  logic              reg_write_q, reg_write_d;
  logic              mem_to_reg_q, mem_to_reg_d;
  logic              mem_write_q, mem_write_d;
  logic [DATA_W-1:0] alu_out_q, alu_out_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
  logic [4:0]        write_reg_q, write_reg_d;

  function automatic logic [DATA_W-1:0] fwd_sel(input logic [1:0] sel,
                                                input logic [DATA_W-1:0] reg_v,
                                                input logic [DATA_W-1:0] wb_v,
                                                input logic [DATA_W-1:0] mem_v);
    case (sel)
      FWD_WB:  return wb_v;
      FWD_MEM: return mem_v;
      default: return reg_v;
    endcase
  endfunction

  assign src_a         = fwd_sel(bus.ForwardAE, bus.RegOut1E, bus.ResultW, alu_out_q);
  assign fwd_b         = fwd_sel(bus.ForwardBE, bus.RegOut2E, bus.ResultW, alu_out_q);
  assign src_b         = bus.ALUSrcE ? bus.ExtendImmE : fwd_b;
  assign shamt         = bus.ExtendImmE[10:6];
  assign bus.WriteRegE = bus.RegDstE ? bus.RdE : bus.RtE;

  // MUL is not an ALU op: it falls to the default (0) in either build.
  always_comb begin
    case (bus.ALUControlE)
      ALU_AND: alu_y = src_a & src_b;
      ALU_OR:  alu_y = src_a | src_b;
      ALU_ADD: alu_y = src_a + src_b;
      ALU_XOR: alu_y = src_a ^ src_b;
      ALU_NOR: alu_y = ~(src_a | src_b);
      ALU_SUB: alu_y = src_a - src_b;
      ALU_SLT: alu_y = ($signed(src_a) < $signed(src_b)) ? DATA_W'(1) : '0;
      ALU_SLL: alu_y = src_b << shamt;
      ALU_SRL: alu_y = src_b >> shamt;
      ALU_SRA: alu_y = $signed(src_b) >>> shamt;
      default: alu_y = '0;
    endcase
  end

`ifdef EX_MUL_EN
  logic              mul_stall, mul_done;
  logic [DATA_W-1:0] mul_product;
  logic [4:0]        mul_wreg;

  seq_multiplier #(
    .DATA_W   (DATA_W),
    .MUL_BITS (MUL_BITS)
  ) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (bus.ALUControlE == ALU_MUL),
    .a_i       (src_a),
    .b_i       (src_b),
    .tag_i     (bus.WriteRegE),
    .stall_o   (mul_stall),
    .done_o    (mul_done),
    .product_o (mul_product),
    .tag_o     (mul_wreg)
  );

  assign bus.StallE = mul_stall;
`else
  assign bus.StallE = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    reg_write_d  = bus.RegWriteE;
    mem_to_reg_d = bus.MemtoRegE;
    mem_write_d  = bus.MemWriteE;
    alu_out_d    = alu_y;
    write_data_d = fwd_b;
    write_reg_d  = bus.WriteRegE;
`ifdef EX_MUL_EN
    if (mul_stall) begin
      reg_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
      mem_write_d  = 1'b0;
      alu_out_d    = '0;
      write_data_d = '0;
      write_reg_d  = '0;
    end else if (mul_done) begin
      alu_out_d   = mul_product;
      write_reg_d = mul_wreg;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      mem_write_q  <= 1'b0;
      alu_out_q    <= '0;
      write_data_q <= '0;
      write_reg_q  <= '0;
    end else begin
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      mem_write_q  <= mem_write_d;
      alu_out_q    <= alu_out_d;
      write_data_q <= write_data_d;
      write_reg_q  <= write_reg_d;
    end
  end

  assign bus.RegWriteM  = reg_write_q;
  assign bus.MemtoRegM  = mem_to_reg_q;
  assign bus.MemWriteM  = mem_write_q;
  assign bus.ALUOutM    = alu_out_q;
  assign bus.WriteDataM = write_data_q;
  assign bus.WriteRegM  = write_reg_q;

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage that sits directly downstream of the ID/EX pipeline register. It consumes the registered E-side control and data, applies forwarding muxes, and runs the ALU or an iterative multiplier.
- It owns the EX/MEM pipeline register, which produces the M-side signals for the memory stage.
- It raises StallE while a multi-cycle multiply is in flight. The hazard unit uses StallE to freeze IF/ID and ID/EX.

Parameters:
- DATA_W, 32, datapath width.
- MUL_BITS, 1, multiplier bits retired per BUSY cycle. Must divide DATA_W. BUSY lasts DATA_W/MUL_BITS cycles.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE  input  1 each  control from ID/EX.
- ALUControlE  input  4  ALU operation.
- RegOut1E, RegOut2E  input  DATA_W  register operands.
- RtE, RdE  input  5  destination candidates.
- ExtendImmE  input  DATA_W  extended immediate; [10:6] is the shift amount.
- ForwardAE, ForwardBE  input  2  forwarding select: 00 register, 01 ResultW, 10 ALUOutM, 11 treated as 00.
- ResultW  input  DATA_W  writeback result.
- StallE  output  1  multiplier busy; hold upstream.
- RegWriteM, MemtoRegM, MemWriteM  output  1 each  registered control.
- ALUOutM, WriteDataM  output  DATA_W  registered result and store data.
- WriteRegM  output  5  registered destination register.
- WriteRegE  output  5  combinational destination, for hazard detection.

Behaviour:
- Reset: all M outputs are 0 and the FSM is IDLE, asynchronously on rst_n low. Reset mid-multiply abandons the operation and StallE drops immediately.
- Forwarding: SrcA = fwd(ForwardAE, RegOut1E). FwdB = fwd(ForwardBE, RegOut2E). SrcB = ALUSrcE ? ExtendImmE : FwdB. WriteRegE = RegDstE ? RdE : RtE.
- ALU encoding: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 NOR, 0110 SUB, 0111 SLT (signed, result 1 or 0), 1000 SLL, 1001 SRL, 1010 SRA, 1100 MUL. Shifts apply to SrcB by ExtendImmE[10:6]. Any other code gives 0. ADD and SUB wrap modulo 2^DATA_W with no overflow flag.
- Single-cycle ops: the EX/MEM register loads {RegWriteE, MemtoRegE, MemWriteE, ALU result, FwdB, WriteRegE} each clk edge. Latency is 1 cycle.
- FSM states are IDLE, BUSY and DONE.
  - IDLE with ALUControlE==1100: latch SrcA, SrcB and WriteRegE, clear the accumulator, count=0, go to BUSY. StallE=1 combinationally in this cycle. EX/MEM loads a bubble (RegWrite, MemWrite and MemtoReg all 0; data 0).
  - BUSY: retire MUL_BITS multiplier bits per cycle (shift-add). StallE=1 and bubbles continue. When count reaches DATA_W/MUL_BITS-1, go to DONE.
  - DONE: StallE=0. EX/MEM loads the low DATA_W bits of the product with the held instruction's control bits and latched WriteReg. Next state is IDLE.
  - The MUL held in ID/EX during DONE does not restart, because DONE→IDLE consumes it on that edge.
- Total stall is 1 + DATA_W/MUL_BITS cycles; with defaults that is 33. The result reaches ALUOutM one edge after DONE.
- Operands are latched at start, so forwarding-source changes during BUSY have no effect.
- A bubble (all control 0) entering EX passes through unchanged. A MUL with RegWriteE=0 still runs and writes nothing.

Optional Feature:
- Macro EX_MUL_EN.
- Defined: MUL is implemented as above.
- Undefined: no FSM or multiplier is built. StallE is tied to 0. Code 1100 yields 0 in a single cycle like any unused code.

Decomposition:
- Shared package pipe_pkg holds:
  - ALU opcode constants (ALU_AND … ALU_MUL).
  - Forward select constants (FWD_REG, FWD_WB, FWD_MEM).
  - The FSM state encoding.
- Natural sub-module: seq_multiplier, containing the FSM, counter, accumulator and busy/done outputs, instantiated only under EX_MUL_EN.
- The ALU and muxes stay inline.

Test Plan:
- Reset: rst_n low mid-cycle → all M outputs 0 immediately; after release, ADD 5+7 → ALUOutM=12 one edge later, WriteRegM=RdE when RegDstE=1.
- Forwarding: RegOut1E=1, ResultW=0x10, ALUOutM=0x100, ForwardAE=10, ForwardBE=01, ADD → ALUOutM=0x110; store data WriteDataM=0x10.
- Ops: SUB 3−5 → 0xFFFFFFFE; SLT −1<1 → 1; SRA 0x80000000 by 4 → 0xF8000000; NOR 0,0 → 0xFFFFFFFF; code 1111 → 0.
- Multiply (EX_MUL_EN): 0x0000FFFF×0x00010001 → StallE high 33 cycles, RegWriteM=0 throughout, then ALUOutM=0xFFFFFFFF with RegWriteM=1. Change ForwardAE during BUSY → result unchanged.
- Reset mid-multiply at BUSY count 10 → StallE=0 at once; next ADD completes normally in 1 cycle.
- Without EX_MUL_EN: MUL code → StallE never asserts, ALUOutM=0 after 1 cycle.
